elevator_scan_ctrl: RTL and testbench
=====================================

# elevator_scan_ctrl

Parametrised successor to the three-floor elevator controller. It serves NUM_FLOORS floors. Call requests are latched into a pending vector, and floors are served with SCAN (elevator-algorithm) ordering that keeps a direction memory. Per-floor travel time and door-open time are counter-based. It drops in wherever the fixed three-floor elevator sits; its Moore outputs match that block, with the floor index added.

## Interface
- NUM_FLOORS, 4: number of floors, 2..16.
- FLOOR_W, $clog2(NUM_FLOORS): width of the floor index.
- TRAVEL_CYCLES, 4: clock cycles to move one floor, ≥1.
- DOOR_CYCLES, 3: clock cycles the doors stay open, ≥1.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- call  in  NUM_FLOORS  request per floor, level or pulse, sampled each rising edge.
- Up  out  1  high in MOVE_UP.
- Down  out  1  high in MOVE_DOWN.
- doors  out  1  high in DOOR_OPEN.
- katastash  out  3  state code: IDLE=000, MOVE_UP=001, MOVE_DOWN=010, DOOR_OPEN=100.
- floor  out  FLOOR_W  current floor.
- pending  out  NUM_FLOORS  latched requests not yet served.

## Operation
- Reset (async, reset=0) sets:
  - state IDLE, so Up=Down=doors=0 and katastash=000;
  - floor=0, pending=0, travel_cnt=0, door_cnt=0, dir_up=1.
- Pending update each edge: pending <= pending | call.
  - Exception: while state is DOOR_OPEN, bit [floor] is forced to 0 and call[floor] is not latched.
- All decisions use the registered pending value, i.e. the value before the edge.
- Let above = any pending bit > floor and below = any pending bit < floor.
- Direction choice (shared by IDLE and the DOOR_OPEN exit):
  - if dir_up and above: go MOVE_UP;
  - else if below: go MOVE_DOWN, dir_up=0;
  - else if above: go MOVE_UP, dir_up=1;
  - else: go IDLE.
- IDLE:
  - if pending[floor]: go DOOR_OPEN, door_cnt=0;
  - else apply the direction choice;
  - with pending=0, stay IDLE.
- MOVE_UP:
  - travel_cnt increments each cycle;
  - at TRAVEL_CYCLES-1: travel_cnt=0 and floor=floor+1;
  - on that same edge, if pending[floor+1]: go DOOR_OPEN, door_cnt=0;
  - else if any pending bit > floor+1: stay MOVE_UP;
  - else go IDLE.
- MOVE_DOWN: mirror of MOVE_UP (floor-1, bits below).
- DOOR_OPEN:
  - door_cnt increments each cycle;
  - at DOOR_CYCLES-1: door_cnt=0 and apply the direction choice.
- Floor bounds: floor never exceeds NUM_FLOORS-1 and never goes below 0. MOVE_UP is entered only with a request above; MOVE_DOWN only with a request below.
- Outputs are Moore outputs decoded from the state register and are glitch-free. floor and pending are registers.
- A request for a floor that was passed is retained and served on the return sweep.

## Timing
- Call at edge k while IDLE at another floor:
  - pending bit visible after edge k;
  - MOVE_UP/MOVE_DOWN entered at edge k+1.
- One floor of travel = TRAVEL_CYCLES cycles of Up or Down.
- floor changes on the same edge that DOOR_OPEN is entered.
- doors is high for exactly DOOR_CYCLES cycles.
- Call for the current floor while IDLE: DOOR_OPEN at edge k+1, with no movement.
- Call for the current floor while DOOR_OPEN: ignored. The timer is not extended.
- Simultaneous calls on several floors all latch on the same edge.
- reset asserted mid-travel or with doors open: everything returns to reset values immediately. Pending requests are lost.
- Reset release: the first active edge is the one after reset rises.

## Test plan
Configuration for all scenarios: NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3, clk period 10 ns.
1. Reset, then pulse call=0010 for 1 cycle → Up=1 for 4 cycles; floor 0→1 at the arrival edge; doors=1 for 3 cycles; then IDLE with pending=0000.
2. From floor 0, pulse call=1010 → stops at floor 1 (doors 3 cycles), then continues up to floor 3 without an intermediate IDLE; pending ends at 0000.
3. At floor 3, calls on 0001 and 0100 are set while doors are open → serves floor 2 first, then floor 0 (SCAN ordering); Down asserted across both legs.
4. dir_up=1 at floor 1 with pending=1001 (floors 0 and 3) → goes up to 3 first, then reverses to 0.
5. Hold call[floor] high during DOOR_OPEN → doors stay high exactly 3 cycles; pending[floor] stays 0; next state IDLE.
6. Assert reset=0 mid-travel between floors 1 and 2 → immediately Up=0, floor=0, pending=0, katastash=000; no movement after release until a new call.

Source files
------------

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: multi-floor elevator controller with SCAN ordering.
// Call requests latch into a pending vector. Travel time and door time are
// counter based. The Moore outputs come from the state register, and a floor
// index is added.
module elevator_scan_ctrl #(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call,
  output logic                  Up,
  output logic                  Down,
  output logic                  doors,
  output logic [2:0]            katastash,
  output logic [FLOOR_W-1:0]    floor,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
  localparam int unsigned TOP_FLOOR = NUM_FLOORS - 1;

  // The state encoding is also the external state code.
  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_MOVE_UP   = 3'b001,
    S_MOVE_DOWN = 3'b010,
    S_DOOR_OPEN = 3'b100
  } state_e;

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TRAVEL_W-1:0]     travel_cnt_q, travel_cnt_d;
  logic [DOOR_W-1:0]       door_cnt_q, door_cnt_d;
  logic                    dir_up_q, dir_up_d;
  logic                    up_q, down_q, doors_q;

  int unsigned             fl;
  logic                    above, below;
  state_e                  choice_state;
  logic                    choice_dir_up;
  logic [NUM_FLOORS-1:0]   here_mask;

  // Returns 1 when any request sits strictly above floor f.
  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input int unsigned f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i > f && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  // Returns 1 when any request sits strictly below floor f.
  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input int unsigned f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i < f && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  // Returns the request bit for floor f (0 if f is out of range).
  function automatic logic req_at(input logic [NUM_FLOORS-1:0] p, input int unsigned f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i == f && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  // Computes the one-hot mask of the current floor and the shared direction choice.
  always_comb begin
    fl            = 32'(floor_q);
    above         = any_above(pending_q, fl);
    below         = any_below(pending_q, fl);
    here_mask     = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i == fl) here_mask[i] = 1'b1;
    end
    choice_state  = S_IDLE;
    choice_dir_up = dir_up_q;
    if (dir_up_q && above) begin
      choice_state  = S_MOVE_UP;
    end else if (below) begin
      choice_state  = S_MOVE_DOWN;
      choice_dir_up = 1'b0;
    end else if (above) begin
      choice_state  = S_MOVE_UP;
      choice_dir_up = 1'b1;
    end
  end

  // Computes the next state, counters, floor and pending requests.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    pending_d    = pending_q | call;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    dir_up_d     = dir_up_q;

    case (state_q)
      S_IDLE: begin
        if (req_at(pending_q, fl)) begin
          state_d    = S_DOOR_OPEN;
          door_cnt_d = '0;
        end else begin
          state_d  = choice_state;
          dir_up_d = choice_dir_up;
        end
      end

      S_MOVE_UP: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          if (fl < TOP_FLOOR) begin
            floor_d = FLOOR_W'(fl + 32'd1);
            if (req_at(pending_q, fl + 32'd1)) begin
              state_d    = S_DOOR_OPEN;
              door_cnt_d = '0;
            end else if (any_above(pending_q, fl + 32'd1)) begin
              state_d = S_MOVE_UP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // Top floor reached with nothing above: should not occur, stop safely.
            state_d = S_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TRAVEL_W'(1);
        end
      end

      S_MOVE_DOWN: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          if (fl > 32'd0) begin
            floor_d = FLOOR_W'(fl - 32'd1);
            if (req_at(pending_q, fl - 32'd1)) begin
              state_d    = S_DOOR_OPEN;
              door_cnt_d = '0;
            end else if (any_below(pending_q, fl - 32'd1)) begin
              state_d = S_MOVE_DOWN;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // Ground floor reached with nothing below: should not occur, stop safely.
            state_d = S_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TRAVEL_W'(1);
        end
      end

      S_DOOR_OPEN: begin
        // A call for the floor being served is dropped, so it cannot extend the door time.
        pending_d = (pending_q | call) & ~here_mask;
        if (door_cnt_q == DOOR_LAST) begin
          door_cnt_d = '0;
          state_d    = choice_state;
          dir_up_d   = choice_dir_up;
        end else begin
          door_cnt_d = door_cnt_q + DOOR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Holds the state and datapath registers, and the output flags decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      floor_q      <= '0;
      pending_q    <= '0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      dir_up_q     <= 1'b1;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      doors_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
      dir_up_q     <= dir_up_d;
      up_q         <= (state_d == S_MOVE_UP);
      down_q       <= (state_d == S_MOVE_DOWN);
      doors_q      <= (state_d == S_DOOR_OPEN);
    end
  end

  assign Up        = up_q;
  assign Down      = down_q;
  assign doors     = doors_q;
  assign katastash = state_q;
  assign floor     = floor_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Testbench for elevator_scan_ctrl.
// Expected motion is queued as segments of (state code, floor, length in cycles).
// A monitor shortens the observed outputs to segments and checks each one against the queue.
module tb_elevator_scan_ctrl;

  localparam int NF = 4;

  logic          clk;
  logic          reset;
  logic [NF-1:0] call;
  logic          Up, Down, doors;
  logic [2:0]    katastash;
  logic [1:0]    floor;
  logic [NF-1:0] pending;

  typedef struct {
    logic [2:0] code;
    logic [1:0] flr;
    int         len;   // 0 = open-ended final segment, only code/floor checked
  } seg_t;

  seg_t       exp_q[$];
  logic [3:0] pend_log[$];
  int         vectors     = 0;
  int         miscompares = 0;

  elevator_scan_ctrl #(
    .NUM_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .call(call),
    .Up(Up), .Down(Down), .doors(doors),
    .katastash(katastash), .floor(floor), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The observation key packs the state code, the three flags and the floor.
  function automatic logic [7:0] key_of(input logic [2:0] c, input logic [1:0] f);
    return {c, c[2], c[1], c[0], f};
  endfunction

  function automatic logic [7:0] obs_key();
    return {katastash, doors, Down, Up, floor};
  endfunction

  task automatic push(input logic [2:0] c, input logic [1:0] f, input int len);
    seg_t s;
    s.code = c; s.flr = f; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic do_reset();
    call  = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs the DUT, applies an optional call window and compares the observed segments.
  task automatic play(input string name, input int max_cyc, input int inj_at,
                      input logic [3:0] inj_val, input int inj_len);
    logic [7:0] cur;
    logic [7:0] obs;
    int         len;
    bit         have;
    bit         done;
    seg_t       e;
    have = 0; done = 0; len = 0; cur = '0;
    pend_log.delete();
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      obs = obs_key();
      pend_log.push_back(pending);
      call = (i >= inj_at && i < inj_at + inj_len) ? inj_val : '0;
      if (have && obs === cur) begin
        len++;
      end else begin
        if (have) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra segment: got key=%b len=%0d, required no further segment", name, cur, len);
            done = 1;
          end else begin
            e = exp_q.pop_front();
            if ({cur, len} !== {key_of(e.code, e.flr), e.len}) begin
              miscompares++;
              $display("FAIL %s segment: got key=%b len=%0d, required key=%b len=%0d",
                       name, cur, len, key_of(e.code, e.flr), e.len);
            end
          end
        end
        if (!done) begin
          cur = obs; len = 1; have = 1;
          if (exp_q.size() > 0 && exp_q[0].len == 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cur !== key_of(e.code, e.flr)) begin
              miscompares++;
              $display("FAIL %s final state: got key=%b, required key=%b", name, cur, key_of(e.code, e.flr));
            end
            done = 1;
          end
        end
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got %0d segments still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    call = '0;
  endtask

  task automatic check_pending(input string name, input logic [3:0] want);
    vectors++;
    if (pending !== want) begin
      miscompares++;
      $display("FAIL %s pending: got %b, required %b", name, pending, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({katastash, Up, Down, doors, floor, pending} !== 11'd0) begin
      miscompares++;
      $display("FAIL %s reset outputs: got state=%b Up=%b Down=%b doors=%b floor=%0d pending=%b, required all 0",
               name, katastash, Up, Down, doors, floor, pending);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    call  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    reset = 1'b1;
    // Open the doors, then hit reset between clock edges.
    call = 4'b0001;
    @(negedge clk);
    call = '0;
    @(negedge clk);
    vectors++;
    if (obs_key() !== key_of(3'b100, 2'd0)) begin
      miscompares++;
      $display("FAIL reset_pre_door: got key=%b, required key=%b", obs_key(), key_of(3'b100, 2'd0));
    end
    #2 reset = 1'b0;
    #1 check_all_zero("reset_async_door");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_call();
    do_reset();
    push(3'b000, 2'd0, 1);
    push(3'b001, 2'd0, 4);
    push(3'b100, 2'd1, 3);
    push(3'b000, 2'd1, 0);
    call = 4'b0010;
    play("single_call", 100, 0, 4'b0000, 0);
    check_pending("single_call_end", 4'b0000);
  endtask

  task automatic test_pass_through();
    do_reset();
    push(3'b000, 2'd0, 1);
    push(3'b001, 2'd0, 4);
    push(3'b100, 2'd1, 3);
    push(3'b001, 2'd1, 4);
    push(3'b001, 2'd2, 4);
    push(3'b100, 2'd3, 3);
    push(3'b000, 2'd3, 0);
    call = 4'b1010;
    play("pass_through", 100, 0, 4'b0000, 0);
    check_pending("pass_through_end", 4'b0000);
  endtask

  task automatic test_scan_down();
    // Continues at floor 3 from the previous scenario; calls arrive with the doors open.
    push(3'b000, 2'd3, 1);
    push(3'b100, 2'd3, 3);
    push(3'b010, 2'd3, 4);
    push(3'b100, 2'd2, 3);
    push(3'b010, 2'd2, 4);
    push(3'b010, 2'd1, 4);
    push(3'b100, 2'd0, 3);
    push(3'b000, 2'd0, 0);
    call = 4'b1000;
    play("scan_down", 100, 1, 4'b0101, 1);
    check_pending("scan_down_end", 4'b0000);
  endtask

  task automatic test_reverse();
    do_reset();
    push(3'b000, 2'd0, 1);
    push(3'b001, 2'd0, 4);
    push(3'b100, 2'd1, 3);
    push(3'b000, 2'd1, 0);
    call = 4'b0010;
    play("reverse_setup", 100, 0, 4'b0000, 0);
    push(3'b000, 2'd1, 1);
    push(3'b001, 2'd1, 4);
    push(3'b001, 2'd2, 4);
    push(3'b100, 2'd3, 3);
    push(3'b010, 2'd3, 4);
    push(3'b010, 2'd2, 4);
    push(3'b010, 2'd1, 4);
    push(3'b100, 2'd0, 3);
    push(3'b000, 2'd0, 0);
    call = 4'b1001;
    play("reverse", 100, 0, 4'b0000, 0);
    check_pending("reverse_end", 4'b0000);
  endtask

  task automatic test_hold_door();
    // Floor 0, idle: hold call[0] through the whole door period.
    push(3'b000, 2'd0, 1);
    push(3'b100, 2'd0, 3);
    push(3'b000, 2'd0, 0);
    call = 4'b0001;
    play("hold_door", 100, 0, 4'b0001, 4);
    for (int k = 2; k <= 4; k++) begin
      vectors++;
      if (k >= pend_log.size()) begin
        miscompares++;
        $display("FAIL hold_door_pending[%0d]: got no sample, required 0000", k);
      end else if (pend_log[k] !== 4'b0000) begin
        miscompares++;
        $display("FAIL hold_door_pending[%0d]: got %b, required 0000", k, pend_log[k]);
      end
    end
    // Nothing may restart once the call is released.
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_key() !== key_of(3'b000, 2'd0)) begin
      miscompares++;
      $display("FAIL hold_door_after: got key=%b, required key=%b", obs_key(), key_of(3'b000, 2'd0));
    end
  endtask

  task automatic test_reset_mid_travel();
    do_reset();
    call = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      call = '0;
    end
    vectors++;
    if (obs_key() !== key_of(3'b001, 2'd1)) begin
      miscompares++;
      $display("FAIL mid_travel_pre: got key=%b, required key=%b", obs_key(), key_of(3'b001, 2'd1));
    end
    #2 reset = 1'b0;
    #1 check_all_zero("mid_travel_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs_key(), pending} !== {key_of(3'b000, 2'd0), 4'b0000}) begin
        miscompares++;
        $display("FAIL mid_travel_after[%0d]: got key=%b pending=%b, required key=%b pending=0000",
                 i, obs_key(), pending, key_of(3'b000, 2'd0));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    call  = '0;
    test_reset();
    test_single_call();
    test_pass_through();
    test_scan_down();
    test_reverse();
    test_hold_door();
    test_reset_mid_travel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
